// File: rtl/lfsr_rr_scheduler.sv
// lfsr_rr_scheduler: two-requester round-robin scheduler that hands out
// 4-bit Fibonacci LFSR values. Each accepted request advances the LFSR by
// STEPS_PER_GRANT shifts, then presents the result for one GRANT cycle.
//
// Optional feature: define LFSR_ZERO_GUARD_EN to replace an all-zero seed
// with 0001 (pulsing seed_err). Left undefined, seeds load verbatim and
// seed_err is tied low; the port list is identical in both builds.
module lfsr_rr_scheduler #(
    parameter int unsigned STEPS_PER_GRANT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       seed_load,
    input  logic [3:0] seed,
    output logic [1:0] gnt,
    output logic       rnd_valid,
    output logic [3:0] rnd_data,
    output logic [3:0] lfsr,
    output logic       output_bit,
    output logic       busy,
    output logic       seed_err
);

    localparam logic [3:0] STEP_LOAD  = 4'(STEPS_PER_GRANT);
    localparam logic [3:0] LFSR_RESET = 4'b0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        GRANT = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] lfsr_q, lfsr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] rnd_data_q, rnd_data_d;
    logic       winner_q, winner_d;   // index of the latched requester
    logic       last_q, last_d;       // index of the requester served last

    logic       seed_accept;
    logic       start;
    logic       arb_pick;
    logic [3:0] seed_eff;
    logic [3:0] lfsr_shift;

    // A seed load takes priority over a pending request in IDLE.
    assign seed_accept = (state_q == IDLE) && seed_load;
    assign start       = (state_q == IDLE) && !seed_load && (req != 2'b00);
    assign lfsr_shift  = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[0]};

`ifdef LFSR_ZERO_GUARD_EN
    logic seed_err_q, seed_err_d;
    logic seed_zero;

    // Substitute the reset value for an all-zero seed so the LFSR cannot lock.
    always_comb begin
        seed_zero  = (seed == '0);
        seed_eff   = seed_zero ? LFSR_RESET : seed;
        seed_err_d = seed_accept && seed_zero;
    end

    // One-cycle error pulse following a substituted seed load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_err_q <= 1'b0;
        end else begin
            seed_err_q <= seed_err_d;
        end
    end

    assign seed_err = seed_err_q;
`else
    assign seed_eff = seed;
    assign seed_err = 1'b0;
`endif

    // Round-robin choice: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        arb_pick = winner_q;
        case (req)
            2'b01:   arb_pick = 1'b0;
            2'b10:   arb_pick = 1'b1;
            2'b11:   arb_pick = ~last_q;
            default: arb_pick = winner_q;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a zero count is treated as the last step for safety.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                if (cnt_q <= 4'd1) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: LFSR, step counter, winner and last-served tracking.
    always_comb begin
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        winner_d   = winner_q;
        last_d     = last_q;
        rnd_data_d = rnd_data_q;
        case (state_q)
            IDLE: begin
                if (seed_accept) begin
                    lfsr_d = seed_eff;
                end else if (start) begin
                    cnt_d    = STEP_LOAD;
                    winner_d = arb_pick;
                end
            end
            STEP: begin
                lfsr_d = lfsr_shift;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GRANT: begin
                last_d     = winner_q;
                rnd_data_d = lfsr_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q     <= LFSR_RESET;
            cnt_q      <= '0;
            winner_q   <= 1'b0;
            last_q     <= 1'b1;
            rnd_data_q <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            winner_q   <= winner_d;
            last_q     <= last_d;
            rnd_data_q <= rnd_data_d;
        end
    end

    // FSM outputs; rnd_data shows the live LFSR during GRANT and the held value otherwise.
    always_comb begin
        gnt       = '0;
        rnd_valid = 1'b0;
        rnd_data  = rnd_data_q;
        busy      = (state_q != IDLE);
        if (state_q == GRANT) begin
            gnt       = winner_q ? 2'b10 : 2'b01;
            rnd_valid = 1'b1;
            rnd_data  = lfsr_q;
        end
    end

    assign lfsr       = lfsr_q;
    assign output_bit = lfsr_q[3];

endmodule
